keypad_matrix_scanner: RTL

//   Reads a ROWS x COLS passive key matrix, the input side of the board I/O path.

---
 rtl/keypad_pkg.sv | 13 +
 rtl/keypad_scan_timer.sv | 44 ++++
 rtl/keypad_matrix_scanner.sv | 138 +++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad matrix scanner.
package keypad_pkg;

  typedef enum logic [1:0] {IDLE, CONFIRM, HELD} state_e;

  typedef enum logic [1:0] {NONE, SINGLE, MULTI} frame_e;

  function automatic int unsigned code_of(input int unsigned row, input int unsigned col,
                                          input int unsigned cols);
    return row * cols + col;
  endfunction

endpackage

// File: rtl/keypad_scan_timer.sv
// Column scan timebase: holds each column low for SCAN_DIV cycles and flags the
// per-column sample point and the end of each full frame.
module keypad_scan_timer #(
  parameter int unsigned COLS     = 4,
  parameter int unsigned SCAN_DIV = 1000,
  localparam int unsigned DIV_W   = $clog2(SCAN_DIV),
  localparam int unsigned COL_W   = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  output logic [COLS-1:0]  col_n,
  output logic [COL_W-1:0] col_idx,
  output logic             sample_stb_c,
  output logic             frame_end_c
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);

  logic [DIV_W-1:0] div_cnt;

  assign sample_stb_c = (div_cnt == DIV_LAST);
  assign frame_end_c  = sample_stb_c && (col_idx == COL_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
      col_idx <= '0;
      col_n   <= ~COLS'(1);
    end else if (sample_stb_c) begin
      div_cnt <= '0;
      if (col_idx == COL_LAST) begin
        col_idx <= '0;
        col_n   <= ~COLS'(1);
      end else begin
        col_idx <= col_idx + COL_W'(1);
        col_n   <= ~(COLS'(1) << (col_idx + COL_W'(1)));
      end
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Scans a passive key matrix, debounces whole frames and reports single key
// presses through a valid/ack handshake; multi-key (ghost) frames are rejected.
module keypad_matrix_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS     = 4,
  parameter int unsigned COLS     = 4,
  parameter int unsigned SCAN_DIV = 1000,
  parameter int unsigned DEBOUNCE = 4,
  localparam int unsigned CODE_W  = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ROWS-1:0]   row_n,
  output logic [COLS-1:0]   col_n,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ack,
  output logic              overrun
);

  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int unsigned CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE - 1);

  logic [ROWS-1:0]   row_meta, row_sync;
  logic [COL_W-1:0]  col_idx;
  logic              sample_stb_c, frame_end_c;
  logic [1:0]        frame_cnt, acc_cnt_c;
  logic [CODE_W-1:0] frame_code, acc_code_c;
  frame_e            frame_res_c;
  logic              accept_c;
  state_e            state;
  logic [CODE_W-1:0] cand;
  logic [CNT_W-1:0]  cnt, rel;

  keypad_scan_timer #(
    .COLS     (COLS),
    .SCAN_DIV (SCAN_DIV)
  ) u_timer (
    .clk          (clk),
    .reset        (reset),
    .col_n        (col_n),
    .col_idx      (col_idx),
    .sample_stb_c (sample_stb_c),
    .frame_end_c  (frame_end_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      row_meta <= '1;
      row_sync <= '1;
    end else begin
      row_meta <= row_n;
      row_sync <= row_meta;
    end
  end

  // Frame tally including the current sample; count saturates at 2 (= MULTI).
  always_comb begin
    acc_cnt_c  = frame_cnt;
    acc_code_c = frame_code;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (!row_sync[r]) begin
        if (acc_cnt_c != 2'd2) acc_cnt_c = acc_cnt_c + 2'd1;
        acc_code_c = CODE_W'(code_of(r, 32'(col_idx), COLS));
      end
    end
    frame_res_c = MULTI;
    if (acc_cnt_c == 2'd0)      frame_res_c = NONE;
    else if (acc_cnt_c == 2'd1) frame_res_c = SINGLE;
  end

  always_comb begin
    accept_c = 1'b0;
    if (frame_end_c && frame_res_c == SINGLE) begin
      if (state == IDLE)         accept_c = (DEBOUNCE == 1);
      else if (state == CONFIRM) accept_c = (acc_code_c == cand) && (cnt == DB_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frame_cnt  <= '0;
      frame_code <= '0;
      state      <= IDLE;
      cand       <= '0;
      cnt        <= '0;
      rel        <= '0;
      key_code   <= '0;
      key_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (key_ack && key_valid) key_valid <= 1'b0;
      if (sample_stb_c) begin
        frame_cnt  <= frame_end_c ? 2'd0 : acc_cnt_c;
        frame_code <= acc_code_c;
      end
      if (frame_end_c) begin
        unique case (state)
          IDLE: begin
            if (frame_res_c == SINGLE) begin
              cand  <= acc_code_c;
              cnt   <= CNT_W'(1);
              state <= CONFIRM;
            end
          end
          CONFIRM: begin
            if (frame_res_c == SINGLE && acc_code_c == cand) cnt <= cnt + CNT_W'(1);
            else state <= IDLE;
          end
          HELD: begin
            if (frame_res_c == NONE) begin
              if (rel == DB_LAST) state <= IDLE;
              else rel <= rel + CNT_W'(1);
            end else begin
              rel <= '0;
            end
          end
          default: state <= IDLE;
        endcase
        // A busy output slot turns the new press into an overrun pulse.
        if (accept_c) begin
          state <= HELD;
          rel   <= '0;
          if (!key_valid) begin
            key_code  <= acc_code_c;
            key_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end
      end
    end
  end

endmodule
